// File: rtl/fir_seq_pkg.sv
// fir_seq_pkg: shared widths and state encoding for the FIR tap sequencer.
package fir_seq_pkg;
    localparam int DW = 18;
    localparam int CW = 28;
    typedef enum logic {IDLE, RUN} state_t;
endpackage

// File: rtl/fir_seq_ram.sv
// fir_seq_ram: simple dual-port RAM, one write port, registered read-first read port.
// The read register clears on rst or when no read is requested, so idle outputs are 0.
module fir_seq_ram
    import fir_seq_pkg::*;
#(
    parameter int W     = DW,
    parameter int DEPTH = 8,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [W-1:0]  wdata_i,
    input  logic          re_i,
    input  logic [AW-1:0] raddr_i,
    output logic [W-1:0]  rdata_o
);
    logic [W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk)
        if (we_i) mem_q[waddr_i] <= wdata_i;

    always_ff @(posedge clk)
        rdata_o <= (rst || !re_i) ? '0 : mem_q[raddr_i];
endmodule

// File: rtl/fir_tap_sequencer.sv
// fir_tap_sequencer: circular sample buffer plus tap sequencer feeding a MAC.
// Define FIRSEQ_OVR_EN to build the sticky overrun flag; otherwise ovr is tied 0.
module fir_tap_sequencer
    import fir_seq_pkg::*;
#(
    parameter int NTAPS = 100,
    parameter int DECIM = 8,
    parameter int AW    = 7
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [DW-1:0] sin,
    input  logic          iv,
    input  logic          cwe,
    input  logic [AW-1:0] caddr,
    input  logic [CW-1:0] cdata,
    output logic [DW-1:0] dout,
    output logic [CW-1:0] cout,
    output logic          first,
    output logic          last,
    output logic          busy,
    output logic          ovr
);
    localparam int PW  = DECIM > 1 ? $clog2(DECIM) : 1;
    localparam int CIW = $clog2(NTAPS);

    state_t        state_q;
    logic [AW-1:0] wptr_q, base_q, k_q;
    logic [PW-1:0] phase_q;
    logic          run, trig, at_end, start;

    assign run    = state_q == RUN;
    assign trig   = iv && phase_q == PW'(DECIM - 1);
    assign at_end = k_q == AW'(NTAPS - 1);
    assign start  = trig && (!run || at_end);
    assign busy   = run;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            wptr_q  <= '0;
            base_q  <= '0;
            k_q     <= '0;
            phase_q <= '0;
            first   <= 1'b0;
            last    <= 1'b0;
        end else begin
            if (iv) wptr_q <= wptr_q + 1'b1;
            if (iv) phase_q <= trig ? '0 : phase_q + 1'b1;
            first <= run && k_q == '0;
            last  <= run && at_end;
            if (start) begin
                state_q <= RUN;
                base_q  <= wptr_q;
                k_q     <= '0;
            end else if (run) begin
                state_q <= at_end ? IDLE : RUN;
                k_q     <= at_end ? '0 : k_q + 1'b1;
            end
        end
    end

`ifdef FIRSEQ_OVR_EN
    logic ovr_q;
    always_ff @(posedge clk)
        if (rst) ovr_q <= 1'b0;
        else if (trig && run && !at_end) ovr_q <= 1'b1;
    assign ovr = ovr_q;
`else
    assign ovr = 1'b0;
`endif

    // Tap 0 is the sample written in the trigger cycle; it is read one cycle later.
    fir_seq_ram #(.W(DW), .DEPTH(2 ** AW), .AW(AW)) u_smem (
        .clk(clk), .rst(rst),
        .we_i(iv), .waddr_i(wptr_q), .wdata_i(sin),
        .re_i(run), .raddr_i(base_q - k_q), .rdata_o(dout)
    );

    fir_seq_ram #(.W(CW), .DEPTH(NTAPS), .AW(CIW)) u_cmem (
        .clk(clk), .rst(rst),
        .we_i(cwe && caddr < AW'(NTAPS)), .waddr_i(caddr[CIW-1:0]), .wdata_i(cdata),
        .re_i(run), .raddr_i(k_q[CIW-1:0]), .rdata_o(cout)
    );
endmodule

// File: tb/tb_fir_tap_sequencer.sv
// tb_fir_tap_sequencer: directed checks of burst timing, overrun, back-to-back,
// coefficient update, mid-burst reset and buffer wrap (NTAPS=4, AW=3).
module tb_fir_tap_sequencer;
    logic        clk = 1'b0, rst = 1'b0;
    logic [17:0] sin_a = '0, sin_b = '0;
    logic        iv_a = 1'b0, iv_b = 1'b0, cwe = 1'b0;
    logic [2:0]  caddr = '0;
    logic [27:0] cdata = '0;
    logic [17:0] dout_a, dout_b;
    logic [27:0] cout_a, cout_b;
    logic        first_a, last_a, busy_a, ovr_a, first_b, last_b, busy_b, ovr_b;
    int          tests = 0, fails = 0;
`ifdef FIRSEQ_OVR_EN
    localparam bit OV = 1'b1;
`else
    localparam bit OV = 1'b0;
`endif

    fir_tap_sequencer #(.NTAPS(4), .DECIM(2), .AW(3)) dut_a (
        .clk(clk), .rst(rst), .sin(sin_a), .iv(iv_a), .cwe(cwe), .caddr(caddr), .cdata(cdata),
        .dout(dout_a), .cout(cout_a), .first(first_a), .last(last_a), .busy(busy_a), .ovr(ovr_a));

    fir_tap_sequencer #(.NTAPS(4), .DECIM(1), .AW(3)) dut_b (
        .clk(clk), .rst(rst), .sin(sin_b), .iv(iv_b), .cwe(cwe), .caddr(caddr), .cdata(cdata),
        .dout(dout_b), .cout(cout_b), .first(first_b), .last(last_b), .busy(busy_b), .ovr(ovr_b));

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic reset_dut();
        rst = 1'b1; step(); step(); rst = 1'b0;
    endtask

    task automatic wr_coef(input logic [2:0] a, input logic [27:0] d);
        cwe = 1'b1; caddr = a; cdata = d; step(); cwe = 1'b0;
    endtask

    task automatic send_a(input logic [17:0] s);
        sin_a = s; iv_a = 1'b1; step(); iv_a = 1'b0;
    endtask

    task automatic send_b(input logic [17:0] s);
        sin_b = s; iv_b = 1'b1; step(); iv_b = 1'b0;
    endtask

    task automatic test_reset();
        reset_dut();
        tests++; if (dout_a !== 18'd0) begin fails++; $display("FAIL reset dout got %0d exp 0", dout_a); end
        tests++; if (cout_a !== 28'd0) begin fails++; $display("FAIL reset cout got %0d exp 0", cout_a); end
        tests++; if ({first_a, last_a, busy_a, ovr_a} !== 4'b0) begin fails++; $display("FAIL reset flags got %b exp 0000", {first_a, last_a, busy_a, ovr_a}); end
        tests++; if ({dout_b, first_b, last_b, busy_b, ovr_b} !== '0) begin fails++; $display("FAIL reset_b outputs not zero got %h", {dout_b, first_b, last_b, busy_b, ovr_b}); end
    endtask

    task automatic test_basic();
        for (int i = 1; i <= 4; i++) wr_coef(3'(i - 1), 28'(i));
        wr_coef(3'd5, 28'd777);
        for (int i = 1; i <= 6; i++) begin
            send_a(18'(i * 10));
            if (i < 6) repeat (4) step();
        end
        tests++; if (busy_a !== 1'b1 || first_a !== 1'b0) begin fails++; $display("FAIL basic start busy/first got %b%b exp 10", busy_a, first_a); end
        for (int k = 0; k < 4; k++) begin
            step();
            tests++; if (dout_a !== 18'(60 - 10 * k)) begin fails++; $display("FAIL basic dout tap%0d got %0d exp %0d", k, dout_a, 60 - 10 * k); end
            tests++; if (cout_a !== 28'(k + 1)) begin fails++; $display("FAIL basic cout tap%0d got %0d exp %0d", k, cout_a, k + 1); end
            tests++; if ({first_a, last_a, busy_a} !== {k == 0, k == 3, k < 3}) begin fails++; $display("FAIL basic flags tap%0d got %b exp %b", k, {first_a, last_a, busy_a}, {k == 0, k == 3, k < 3}); end
        end
        step();
        tests++; if ({dout_a, cout_a, first_a, last_a, busy_a} !== '0) begin fails++; $display("FAIL basic idle outputs got %h exp 0", {dout_a, cout_a, first_a, last_a, busy_a}); end
    endtask

    task automatic test_overrun();
        reset_dut();
        for (int c = 0; c < 10; c++) begin
            iv_a = c < 6; sin_a = 18'(c + 1);
            step();
            iv_a = 1'b0;
            begin
                int o = c + 1;
                tests++; if ({first_a, last_a, busy_a} !== {o == 3 || o == 7, o == 6 || o == 10, o >= 2 && o <= 9}) begin fails++; $display("FAIL ovr flags cyc%0d got %b", o, {first_a, last_a, busy_a}); end
                tests++; if (ovr_a !== (OV && o >= 4)) begin fails++; $display("FAIL ovr flag cyc%0d got %b exp %b", o, ovr_a, OV && o >= 4); end
                if (o >= 7) begin
                    tests++; if (dout_a !== 18'(13 - o) || cout_a !== 28'(o - 6)) begin fails++; $display("FAIL ovr tap cyc%0d got %0d/%0d exp %0d/%0d", o, dout_a, cout_a, 13 - o, o - 6); end
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        reset_dut();
        for (int c = 0; c < 11; c++) begin
            iv_a = (c % 2 == 0) && c <= 6; sin_a = 18'(11 + c / 2);
            step();
            iv_a = 1'b0;
            begin
                int o = c + 1;
                tests++; if ({first_a, last_a, busy_a} !== {o == 4 || o == 8, o == 7 || o == 11, o >= 3 && o <= 10}) begin fails++; $display("FAIL b2b flags cyc%0d got %b", o, {first_a, last_a, busy_a}); end
                if (o >= 8) begin
                    tests++; if (dout_a !== 18'(22 - o) || cout_a !== 28'(o - 7)) begin fails++; $display("FAIL b2b tap cyc%0d got %0d/%0d exp %0d/%0d", o, dout_a, cout_a, 22 - o, o - 7); end
                end
            end
        end
        tests++; if (ovr_a !== 1'b0) begin fails++; $display("FAIL b2b ovr got %b exp 0", ovr_a); end
    endtask

    task automatic test_coef_update();
        reset_dut();
        send_a(18'd1); send_a(18'd2);
        step();
        tests++; if (cout_a !== 28'd1) begin fails++; $display("FAIL coef tap0 got %0d exp 1", cout_a); end
        step();
        cwe = 1'b1; caddr = 3'd2; cdata = 28'd99;
        step();
        cwe = 1'b0;
        tests++; if (cout_a !== 28'd3) begin fails++; $display("FAIL coef old tap2 got %0d exp 3", cout_a); end
        step();
        tests++; if (cout_a !== 28'd4) begin fails++; $display("FAIL coef tap3 got %0d exp 4", cout_a); end
        repeat (2) step();
        send_a(18'd3); send_a(18'd4);
        repeat (3) step();
        tests++; if (cout_a !== 28'd99) begin fails++; $display("FAIL coef new tap2 got %0d exp 99", cout_a); end
        repeat (2) step();
        wr_coef(3'd2, 28'd3);
    endtask

    task automatic test_reset_mid();
        reset_dut();
        send_a(18'd5); send_a(18'd6);
        repeat (2) step();
        tests++; if (dout_a !== 18'd5 || cout_a !== 28'd2) begin fails++; $display("FAIL rstmid tap1 got %0d/%0d exp 5/2", dout_a, cout_a); end
        rst = 1'b1; step(); rst = 1'b0;
        tests++; if ({dout_a, cout_a, first_a, last_a, busy_a} !== '0) begin fails++; $display("FAIL rstmid outputs got %h exp 0", {dout_a, cout_a, first_a, last_a, busy_a}); end
        send_a(18'd7);
        step();
        tests++; if (busy_a !== 1'b0) begin fails++; $display("FAIL rstmid early trigger busy got %b exp 0", busy_a); end
        send_a(18'd8);
        tests++; if (busy_a !== 1'b1) begin fails++; $display("FAIL rstmid trigger busy got %b exp 1", busy_a); end
        step();
        tests++; if (first_a !== 1'b1 || dout_a !== 18'd8) begin fails++; $display("FAIL rstmid first tap got %b/%0d exp 1/8", first_a, dout_a); end
        repeat (4) step();
    endtask

    task automatic test_wrap();
        reset_dut();
        for (int i = 1; i <= 20; i++) begin
            send_b(18'(i));
            if (i == 18 || i == 20) begin
                for (int k = 0; k < 4; k++) begin
                    step();
                    tests++; if (dout_b !== 18'(i - k) || cout_b !== 28'(k + 1)) begin fails++; $display("FAIL wrap s%0d tap%0d got %0d/%0d exp %0d/%0d", i, k, dout_b, cout_b, i - k, k + 1); end
                end
            end else repeat (3) step();
        end
        tests++; if (ovr_b !== 1'b0) begin fails++; $display("FAIL wrap ovr got %b exp 0", ovr_b); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_overrun();
        test_back_to_back();
        test_coef_update();
        test_reset_mid();
        test_wrap();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
